tc_pl_cap_gain_read: RTL and testbench

- Read-back engine for the gain-partitioned capture buffer.
- The capture side writes points for gain g into the region starting at cap_addr + g*(cap_points<<4), one point every 16 address units.
- On a start pulse, this block walks the selected gain's region and issues one memory read per point, limiting how many reads are outstanding at once.
- Returned data is forwarded as a point stream with a last-point marker, plus done and error status for the PS-side control logic.

---
 rtl/tc_pl_cap_gain_read.sv | 156 +++++++++++++++
 tb/tb_tc_pl_cap_gain_read.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_pl_cap_gain_read.sv
// tc_pl_cap_gain_read
//   Read-back engine for the gain-partitioned capture buffer. On a start
//   pulse it walks the region of the selected gain, one read per point
//   (16 address units apart), with at most MAX_OUTST reads awaiting data.
//   Returned data is forwarded as a registered point stream.
//
// Ports
//   clk, rst           clock, asynchronous active-low reset
//   start              one-cycle start pulse (honoured in IDLE only)
//   gain_value         gain region to read
//   cap_points         points per gain region
//   cap_addr           capture buffer base address
//   rd_req/rd_addr     read request and its address
//   rd_ack             request accepted (transfer when rd_req && rd_ack)
//   rd_dvld/rd_data    read data return
//   out_valid/out_data registered point stream, out_last on the final point
//   busy               read-back in progress
//   done               one-cycle completion pulse
//   rd_err             sticky: read data returned with nothing outstanding
module tc_pl_cap_gain_read #(
  parameter int CAP0_1    = 3,
  parameter int CAP0_6    = 14,
  parameter int CAP0_7    = 32,
  parameter int DATA_W    = 64,
  parameter int MAX_OUTST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CAP0_1-2:0]   gain_value,
  input  logic [CAP0_6-1:0]   cap_points,
  input  logic [CAP0_7-1:0]   cap_addr,
  output logic                rd_req,
  output logic [CAP0_7-1:0]   rd_addr,
  input  logic                rd_ack,
  input  logic                rd_dvld,
  input  logic [DATA_W-1:0]   rd_data,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  output logic                busy,
  output logic                done,
  output logic                rd_err
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTST);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t              state_q, state_d;
  logic [CAP0_7-1:0]   addr_q, addr_d;
  logic [CAP0_6-1:0]   pts_q, pts_d;
  logic [CAP0_6-1:0]   iss_q, iss_d;
  logic [CAP0_6-1:0]   rcv_q, rcv_d;
  logic [OW-1:0]       outst_q, outst_d;
  logic                err_q, err_d;
  logic                ov_q, ov_d;
  logic [DATA_W-1:0]   od_q, od_d;
  logic                ol_q, ol_d;

  logic                accept;
  logic                good_dvld;
  logic                final_rsp;
  logic [CAP0_7-1:0]   base_calc;

  // Shift before multiply, multiply before add, all modulo 2^CAP0_7.
  assign base_calc = cap_addr + (CAP0_7'(gain_value) * (CAP0_7'(cap_points) << 4));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pts_d   = pts_q;
    iss_d   = iss_q;
    rcv_d   = rcv_q;
    outst_d = outst_q;
    err_d   = err_q;
    od_d    = od_q;

    rd_req    = (state_q == RUN) && (iss_q < pts_q) && (outst_q < MAX_O);
    accept    = rd_req && rd_ack;
    // Only data matching an outstanding read is forwarded and counted.
    good_dvld = rd_dvld && (state_q == RUN) && (outst_q != '0);
    final_rsp = good_dvld && ((rcv_q + CAP0_6'(1)) == pts_q);

    ov_d = good_dvld;
    ol_d = final_rsp;
    if (good_dvld) od_d = rd_data;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = base_calc;
          pts_d   = cap_points;
          iss_d   = '0;
          rcv_d   = '0;
          outst_d = '0;
          err_d   = 1'b0;
          state_d = (cap_points == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          iss_d  = iss_q + CAP0_6'(1);
          addr_d = addr_q + CAP0_7'(16);
        end
        if (good_dvld) rcv_d = rcv_q + CAP0_6'(1);
        outst_d = outst_q + OW'(accept) - OW'(good_dvld);
        if (final_rsp) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (rd_dvld && !good_dvld) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      pts_q   <= '0;
      iss_q   <= '0;
      rcv_q   <= '0;
      outst_q <= '0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      ol_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pts_q   <= pts_d;
      iss_q   <= iss_d;
      rcv_q   <= rcv_d;
      outst_q <= outst_d;
      err_q   <= err_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ol_q    <= ol_d;
    end
  end

  assign rd_addr   = addr_q;
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_last  = ol_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == FIN);
  assign rd_err    = err_q;

endmodule

// File: tb/tb_tc_pl_cap_gain_read.sv
module tb_tc_pl_cap_gain_read;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int PW = 14;
  localparam int GW = 2;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [GW-1:0] gain_value = '0;
  logic [PW-1:0] cap_points = '0;
  logic [AW-1:0] cap_addr = '0;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack = 1'b0;
  logic          rd_dvld = 1'b0;
  logic [DW-1:0] rd_data = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          rd_err;

  tc_pl_cap_gain_read #(
    .CAP0_1(3), .CAP0_6(PW), .CAP0_7(AW), .DATA_W(DW), .MAX_OUTST(MO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .gain_value(gain_value),
    .cap_points(cap_points), .cap_addr(cap_addr),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_dvld(rd_dvld), .rd_data(rd_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  typedef struct { logic [DW-1:0] d; logic last; } beat_t;
  typedef struct { logic [AW-1:0] a; int due; } pend_t;

  beat_t         exp_q[$];
  pend_t         pend_q[$];
  logic [AW-1:0] addr_q[$];
  logic [AW-1:0] acc_log[$];

  // stimulus controls (written by the main sequence only)
  int ack_mode = 0;   // 0: tied 1, 1: random, 2: held 0
  int lat_min = 2, lat_max = 2;
  bit withhold = 0;
  int rel_cnt = 0;
  int stray_cnt = 0;

  // reference model state (written by the memory/driver process only)
  bit            m_busy = 0;
  int            m_wait = 0;
  int            m_pts = 0, m_iss = 0, m_rcv = 0, m_outst = 0;
  bit            m_err = 0;
  logic [AW-1:0] m_salt = '0;
  int            cyc = 0, tot_acc = 0, rel_done = 0, stray_done = 0;
  bit            prev_stall = 0;
  logic [AW-1:0] prev_addr = '0;

  int n_beats = 0, n_done = 0;

  function automatic logic [DW-1:0] mem_data(logic [AW-1:0] a, logic [AW-1:0] s);
    return {a ^ s, ~a};
  endfunction

  // Memory model, request/ack driver and cycle-level reference checks.
  always @(negedge clk) begin
    bit ack, ret, stray;
    bit exp_req;
    cyc++;
    if (!rst) begin
      m_busy = 0; m_wait = 0; m_pts = 0; m_iss = 0; m_rcv = 0; m_outst = 0;
      m_err = 0; prev_stall = 0;
      pend_q.delete(); addr_q.delete();
      rd_ack = 0; rd_dvld = 0;
    end else begin
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) m_busy = 0;
      end
      exp_req = m_busy && (m_wait == 0) && (m_iss < m_pts) && (m_outst < MO);
      check("rd_req", 64'(rd_req), 64'(exp_req));
      check("busy", 64'(busy), 64'(m_busy && (m_wait == 0)));
      check("done", 64'(done), 64'(m_wait == 1));
      check("rd_err", 64'(rd_err), 64'(m_err));
      if (prev_stall) check("addr_stable", 64'(rd_addr), 64'(prev_addr));

      ack = (ack_mode == 0) ? 1'b1 : (ack_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      rd_ack = ack;
      if (rd_req && ack) begin
        if (addr_q.size() == 0) check("unexpected_accept", 64'(rd_addr), 64'hDEAD);
        else check("rd_addr", 64'(rd_addr), 64'(addr_q.pop_front()));
        pend_q.push_back('{a: rd_addr, due: cyc + int'($urandom_range(lat_min, lat_max))});
        acc_log.push_back(rd_addr);
        m_iss++; tot_acc++; m_outst++;
      end
      prev_stall = rd_req && !ack;
      prev_addr  = rd_addr;

      ret = 0; stray = 0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc && (!withhold || rel_done < rel_cnt)) begin
        pend_t p;
        ret = 1;
        if (withhold) rel_done++;
        p = pend_q.pop_front();
        rd_data = mem_data(p.a, m_salt);
        m_rcv++; m_outst--;
        if (m_rcv == m_pts) m_wait = 2;
      end else if (stray_done < stray_cnt && !m_busy) begin
        stray = 1;
        stray_done++;
        rd_data = {$urandom, $urandom};
        m_err = 1;
      end
      rd_dvld = ret || stray;

      if (start && !m_busy) begin
        logic [AW-1:0] b;
        b = cap_addr + 32'(gain_value) * (32'(cap_points) * 32'd16);
        m_busy = 1; m_pts = int'(cap_points); m_iss = 0; m_rcv = 0; m_outst = 0;
        m_err = 0; m_salt = $urandom;
        for (int i = 0; i < m_pts; i++) begin
          addr_q.push_back(b + 32'(i) * 32'd16);
          exp_q.push_back('{d: mem_data(b + 32'(i) * 32'd16, m_salt), last: (i == m_pts - 1)});
        end
        if (m_pts == 0) m_wait = 2;
      end
    end
  end

  // Output monitor: pops the scoreboard on every presented point.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
    end else begin
      if (done) n_done++;
      if (out_valid) begin
        n_beats++;
        if (exp_q.size() == 0) check("unexpected_beat", out_data, 64'hBAD);
        else begin
          beat_t e;
          e = exp_q.pop_front();
          check("out_data", out_data, e.d);
          check("out_last", 64'(out_last), 64'(e.last));
        end
      end
    end
  end

  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(logic [AW-1:0] a, int p, int g);
    @(posedge clk); #1;
    cap_addr = a; cap_points = PW'(p); gain_value = GW'(g); start = 1;
    @(posedge clk); #1;
    start = 0;
    cap_addr = $urandom; cap_points = PW'($urandom); gain_value = GW'($urandom);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 0;
    cycles(3);
    rst = 1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (m_busy && k < 3000) begin cycles(1); k++; end
    if (m_busy) begin
      check("idle_timeout", 64'(k), 64'(0));
      do_reset();
    end
    cycles(1);
  endtask

  task automatic check_addrs(int from, logic [AW-1:0] a0, logic [AW-1:0] a1);
    if (acc_log.size() < from + 2) check("acc_count", 64'(acc_log.size()), 64'(from + 2));
    else begin
      check("addr0", 64'(acc_log[from]), 64'(a0));
      check("addr1", 64'(acc_log[from + 1]), 64'(a1));
    end
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_rd_req"}, 64'(rd_req), 0);
    check({tag, "_rd_addr"}, 64'(rd_addr), 0);
    check({tag, "_out_valid"}, 64'(out_valid), 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, 64'(out_last), 0);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_done"}, 64'(done), 0);
    check({tag, "_rd_err"}, 64'(rd_err), 0);
  endtask

  initial begin
    int a0, b0, d0;
    cycles(3);
    check_all_zero("reset");
    rst = 1;
    cycles(2);

    // basic gain 0
    a0 = acc_log.size(); b0 = n_beats; d0 = n_done;
    pulse_start(32'h1000, 3, 0);
    wait_idle();
    check_addrs(a0, 32'h1000, 32'h1010);
    if (acc_log.size() > a0 + 2) check("addr2", 64'(acc_log[a0 + 2]), 64'h1020);
    check("basic_beats", 64'(n_beats - b0), 3);
    check("basic_done", 64'(n_done - d0), 1);

    // gain offset
    a0 = acc_log.size();
    pulse_start(32'h1000, 2, 3);
    wait_idle();
    check_addrs(a0, 32'h1060, 32'h1070);

    // outstanding limit
    a0 = tot_acc;
    withhold = 1; lat_min = 1; lat_max = 1;
    pulse_start(32'h2000, 10, 1);
    cycles(12);
    check("limit_accepts", 64'(tot_acc - a0), 4);
    check("limit_rd_req", 64'(rd_req), 0);
    rel_cnt++;
    cycles(6);
    check("limit_one_more", 64'(tot_acc - a0), 5);
    withhold = 0;
    wait_idle();
    check("limit_total", 64'(tot_acc - a0), 10);

    // stall then wrap
    a0 = acc_log.size();
    ack_mode = 2;
    pulse_start(32'hFFFF_FFF0, 2, 0);
    cycles(5);
    check("stall_addr", 64'(rd_addr), 64'hFFFF_FFF0);
    ack_mode = 0;
    wait_idle();
    check_addrs(a0, 32'hFFFF_FFF0, 32'h0000_0000);

    // zero points
    a0 = tot_acc; d0 = n_done;
    pulse_start(32'h3000, 0, 2);
    wait_idle();
    check("zero_accepts", 64'(tot_acc - a0), 0);
    check("zero_done", 64'(n_done - d0), 1);

    // start during RUN ignored
    a0 = tot_acc; ack_mode = 1; lat_min = 1; lat_max = 4;
    pulse_start(32'h4000, 6, 1);
    cycles(2);
    pulse_start(32'h8000, 9, 2);
    wait_idle();
    check("ignored_start", 64'(tot_acc - a0), 6);

    // stray data in IDLE, cleared by next start
    stray_cnt++;
    cycles(3);
    check("stray_err", 64'(rd_err), 1);
    pulse_start(32'h5000, 1, 0);
    check("err_cleared", 64'(rd_err), 0);
    wait_idle();

    // reset mid-run
    ack_mode = 0; lat_min = 2; lat_max = 2;
    b0 = n_beats;
    pulse_start(32'h6000, 5, 1);
    for (int k = 0; k < 100 && (n_beats - b0) < 2; k++) cycles(1);
    check("pre_reset_beats", 64'(n_beats - b0), 2);
    #2 rst = 0;
    #1 check_all_zero("midreset");
    cycles(3);
    d0 = n_done;
    rst = 1;
    cycles(4);
    check("no_done_after_reset", 64'(n_done - d0), 0);
    b0 = n_beats;
    pulse_start(32'h7000, 4, 2);
    wait_idle();
    check("fresh_beats", 64'(n_beats - b0), 4);

    // randomized transfers
    ack_mode = 1;
    for (int t = 0; t < 30; t++) begin
      lat_min = 1; lat_max = int'($urandom_range(1, 6));
      b0 = n_beats;
      d0 = int'($urandom_range(0, 12));
      pulse_start($urandom, d0, int'($urandom_range(0, 3)));
      wait_idle();
      check("rand_beats", 64'(n_beats - b0), 64'(d0));
    end

    cycles(4);
    check("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
